// File: rtl/stream_sink_fifo_if.sv
// Bundle of the push-side, pop-side and overflow-status signals of stream_sink_fifo.
// The slave modport is the FIFO; the master modport is the surrounding logic.
interface stream_sink_fifo_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 8
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH:0]   level;
  logic                  overflow;
  logic                  ovf_clear;
  logic [CNT_WIDTH-1:0]  drop_count;

  modport slave (
    input  in_valid, in_data, out_ready, ovf_clear,
    output out_valid, out_data, level, overflow, drop_count
  );

  modport master (
    output in_valid, in_data, out_ready, ovf_clear,
    input  out_valid, out_data, level, overflow, drop_count
  );
endinterface

// File: rtl/stream_sink_fifo.sv
// Reader end of a no-backpressure stream: buffers pushes in a first-word
// fall-through FIFO and exposes ready/valid, counting any pushes it must drop.
module stream_sink_fifo #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input logic              clk,
  input logic              arst_n,
  stream_sink_fifo_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   level_q;
  logic                  overflow_q;
  logic [CNT_WIDTH-1:0]  drop_q;

  logic not_empty;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Handshake decode uses registered state only, so out_valid never depends on out_ready.
  always_comb begin
    not_empty = (level_q != '0);
    full      = (level_q == FULL_LEVEL);
    pop       = not_empty & bus.out_ready;
    push      = bus.in_valid & (~full | pop);
    drop      = bus.in_valid & ~push;
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level_q <= level_q + 1'b1;
      end else if (pop && !push) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

  // A drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (bus.ovf_clear) begin
        drop_q <= CNT_WIDTH'(1);
      end else if (drop_q != '1) begin
        drop_q <= drop_q + 1'b1;
      end
    end else if (bus.ovf_clear) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end
  end

  always_comb begin
    bus.out_valid  = not_empty;
    bus.out_data   = mem[rd_ptr];
    bus.level      = level_q;
    bus.overflow   = overflow_q;
    bus.drop_count = drop_q;
  end
endmodule

// File: tb/tb_stream_sink_fifo.sv
// Bench for stream_sink_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_stream_sink_fifo;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned CW = 8;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic arst_n = 1'b1;

  stream_sink_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  stream_sink_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model: plain queue plus overflow bookkeeping.
  logic [DW-1:0] mq[$];
  bit m_ovf = 1'b0;
  int m_cnt = 0;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_cnt = 0;
    end else begin
      bit can_pop;
      bit accepted;
      can_pop  = (mq.size() != 0) && bus.out_ready;
      accepted = bus.in_valid && ((mq.size() < DEPTH) || can_pop);
      if (can_pop) void'(mq.pop_front());
      if (accepted) mq.push_back(bus.in_data);
      if (bus.in_valid && !accepted) begin
        m_ovf = 1'b1;
        if (bus.ovf_clear) m_cnt = 1;
        else if (m_cnt < 255) m_cnt = m_cnt + 1;
      end else if (bus.ovf_clear) begin
        m_ovf = 1'b0;
        m_cnt = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_level", 32'(bus.level), 32'(mq.size()));
      check("m_out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
      check("m_overflow", 32'(bus.overflow), 32'(m_ovf));
      check("m_drop_count", 32'(bus.drop_count), 32'(m_cnt));
      if (mq.size() != 0) check("m_out_data", 32'(bus.out_data), 32'(mq[0]));
    end
  end

  // Apply inputs for one cycle; returns 1 time unit after the edge that consumed them.
  task automatic cyc(input bit iv, input logic [DW-1:0] d, input bit rdy, input bit clr);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = rdy;
    bus.ovf_clear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic drain_and_clear();
    for (int i = 0; i < 20; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.ovf_clear = 1'b0;
    #1 arst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 arst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_level", 32'(bus.level), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_overflow", 32'(bus.overflow), 0);
    check("rst_drop_count", 32'(bus.drop_count), 0);
    chk_en = 1'b1;

    // Single push into empty FIFO
    cyc(1'b1, 16'h1234, 1'b0, 1'b0);
    check("t1_out_valid", 32'(bus.out_valid), 1);
    check("t1_out_data", 32'(bus.out_data), 32'h1234);
    check("t1_level", 32'(bus.level), 1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("t1_level_after_pop", 32'(bus.level), 0);
    check("t1_out_valid_after_pop", 32'(bus.out_valid), 0);

    // Fill, overflow by one, drain in order
    for (int i = 0; i < 16; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0);
    cyc(1'b1, 16'hBEEF, 1'b0, 1'b0);
    check("t2_level", 32'(bus.level), 16);
    check("t2_overflow", 32'(bus.overflow), 1);
    check("t2_drop_count", 32'(bus.drop_count), 1);
    check("t2_model_size", 32'(mq.size()), 16);
    for (int i = 0; i < 16; i++) begin
      check("t2_drain_valid", 32'(bus.out_valid), 1);
      check("t2_drain_data", 32'(bus.out_data), 32'(i));
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
    check("t2_empty", 32'(bus.level), 0);
    check("t2_overflow_sticky", 32'(bus.overflow), 1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    check("t2_clr_overflow", 32'(bus.overflow), 0);
    check("t2_clr_drop_count", 32'(bus.drop_count), 0);

    // Full with simultaneous push and pop across pointer wrap
    for (int i = 0; i < 16; i++) cyc(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      check("t3_head", 32'(bus.out_data), (k < 16) ? 32'(32'h100 + k) : 32'(32'h200 + k - 16));
      cyc(1'b1, 16'(16'h0200 + k), 1'b1, 1'b0);
      check("t3_level", 32'(bus.level), 16);
    end
    check("t3_drop_count", 32'(bus.drop_count), 0);
    check("t3_overflow", 32'(bus.overflow), 0);
    drain_and_clear();

    // Saturating drop counter, then clear colliding with a drop
    for (int i = 0; i < 16; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) cyc(1'b1, 16'hDEAD, 1'b0, 1'b0);
    check("t4_drop_sat", 32'(bus.drop_count), 255);
    check("t4_overflow", 32'(bus.overflow), 1);
    cyc(1'b1, 16'hDEAD, 1'b0, 1'b1);
    check("t4_clr_drop_overflow", 32'(bus.overflow), 1);
    check("t4_clr_drop_count", 32'(bus.drop_count), 1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    check("t4_clr_count", 32'(bus.drop_count), 0);
    check("t4_head_kept", 32'(bus.out_data), 0);
    drain_and_clear();

    // Random traffic against the model
    for (int i = 0; i < 10000; i++)
      cyc(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 99) == 0));
    drain_and_clear();

    // Asynchronous reset mid-cycle with data queued
    for (int i = 0; i < 9; i++) cyc(1'b1, 16'(16'h0300 + i), 1'b0, 1'b0);
    check("t6_level_before", 32'(bus.level), 9);
    #2 arst_n = 1'b0;
    #1;
    check("t6_rst_level", 32'(bus.level), 0);
    check("t6_rst_out_valid", 32'(bus.out_valid), 0);
    #10 arst_n = 1'b1;
    cyc(1'b1, 16'h00A5, 1'b0, 1'b0);
    check("t6_out_valid", 32'(bus.out_valid), 1);
    check("t6_out_data", 32'(bus.out_data), 32'hA5);
    check("t6_level", 32'(bus.level), 1);
    drain_and_clear();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
